// File: rtl/mod_n_serial_checker_pkg.sv
// Shared types and legal parameter bounds for the serial mod-N checker.
package mod_n_pkg;
  localparam int DIVISOR_MIN = 2;
  localparam int DIVISOR_MAX = 255;

  typedef enum logic {
    IDLE = 1'b0,
    ACC  = 1'b1
  } state_t;
endpackage

// File: rtl/mod_n_serial_checker_addsub.sv
// Combinational (a + b) mod DIVISOR for a, b < DIVISOR: one add, one conditional subtract.
module mod_n_addsub import mod_n_pkg::*; #(
  parameter int DIVISOR = 3,
  parameter int RW      = $clog2(DIVISOR)
) (
  input  logic [RW-1:0] a,
  input  logic [RW-1:0] b,
  output logic [RW-1:0] y
);
  logic [RW:0] sum;

  always_comb begin
    sum = {1'b0, a} + {1'b0, b};
    y   = (sum >= (RW+1)'(DIVISOR)) ? RW'(sum - (RW+1)'(DIVISOR)) : sum[RW-1:0];
  end
endmodule

// File: rtl/mod_n_serial_checker.sv
// Framed serial divisibility checker: running remainder mod DIVISOR, MSB- or LSB-first per frame,
// with registered per-frame result, done/abort/err pulses and a saturating bit counter.
module mod_n_serial_checker import mod_n_pkg::*; #(
  parameter  int DIVISOR = 3,
  parameter  int CNT_W   = 16,
  localparam int RW      = $clog2(DIVISOR)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  input  logic             i_bit,
  input  logic             i_sop,
  input  logic             i_eop,
  input  logic             i_lsb_first,
  output logic [RW-1:0]    o_rem,
  output logic             o_busy,
  output logic             o_done,
  output logic [RW-1:0]    o_result_rem,
  output logic             o_result_div,
  output logic [CNT_W-1:0] o_bit_count,
  output logic             o_abort,
  output logic             o_err
);
  generate
    if (DIVISOR < DIVISOR_MIN || DIVISOR > DIVISOR_MAX) begin : g_bad_divisor
      $error("mod_n_serial_checker: DIVISOR out of range 2..255");
    end
    if (CNT_W < 1) begin : g_bad_cnt_w
      $error("mod_n_serial_checker: CNT_W must be >= 1");
    end
  endgenerate

  state_t           state;
  logic [RW-1:0]    w_q;
  logic             lsb_q;
  logic [CNT_W-1:0] cnt_q;

  logic             start, accept, lsb_cur;
  logic [RW-1:0]    base_rem, base_w, dbl_rem, add_a, add_b, rem_next, w_next;
  logic [CNT_W-1:0] cnt_next;

  // A sop beat restarts from rem=0, w=1 before its own bit is folded in.
  always_comb begin
    start    = i_valid && i_sop;
    accept   = i_valid && (state == ACC || i_sop);
    base_rem = start ? '0 : o_rem;
    base_w   = start ? RW'(1) : w_q;
    lsb_cur  = start ? i_lsb_first : lsb_q;
    add_a    = lsb_cur ? base_rem : dbl_rem;
    add_b    = lsb_cur ? (i_bit ? base_w : '0) : RW'(i_bit);
    cnt_next = start ? CNT_W'(1) : (&cnt_q ? cnt_q : cnt_q + 1'b1);
  end

  mod_n_addsub #(.DIVISOR(DIVISOR), .RW(RW)) u_dbl_rem (.a(base_rem), .b(base_rem), .y(dbl_rem));
  mod_n_addsub #(.DIVISOR(DIVISOR), .RW(RW)) u_acc     (.a(add_a),    .b(add_b),    .y(rem_next));
  mod_n_addsub #(.DIVISOR(DIVISOR), .RW(RW)) u_dbl_w   (.a(base_w),   .b(base_w),   .y(w_next));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state        <= IDLE;
      o_rem        <= '0;
      w_q          <= RW'(1);
      lsb_q        <= 1'b0;
      cnt_q        <= '0;
      o_busy       <= 1'b0;
      o_done       <= 1'b0;
      o_result_rem <= '0;
      o_result_div <= 1'b0;
      o_bit_count  <= '0;
      o_abort      <= 1'b0;
      o_err        <= 1'b0;
    end else begin
      o_done  <= 1'b0;
      o_abort <= 1'b0;
      o_err   <= 1'b0;
      if (accept) begin
        o_rem <= rem_next;
        w_q   <= w_next;
        lsb_q <= lsb_cur;
        cnt_q <= cnt_next;
        if (start && state == ACC) o_abort <= 1'b1;
        if (i_eop) begin
          state        <= IDLE;
          o_busy       <= 1'b0;
          o_done       <= 1'b1;
          o_result_rem <= rem_next;
          o_result_div <= (rem_next == '0);
          o_bit_count  <= cnt_next;
        end else begin
          state  <= ACC;
          o_busy <= 1'b1;
        end
      end else if (i_valid && state == IDLE) begin
        // Data outside a frame is dropped, including any eop flag on it.
        o_err <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_mod_n_serial_checker.sv
// Directed + randomized bench: five checkers (DIVISOR 2,3,5,7,13) share one stimulus stream.
module tb_mod_n_serial_checker;
  localparam int NI       = 5;
  localparam int DIVS[NI] = '{2, 3, 5, 7, 13};
  localparam int CWS[NI]  = '{16, 16, 3, 16, 16};
  localparam int CMAX[NI] = '{65535, 65535, 7, 65535, 65535};
  localparam int I2 = 0, I3 = 1, I5 = 2, I7 = 3;

  logic i_clk, i_rst, i_valid, i_bit, i_sop, i_eop, i_lsb_first;
  logic [7:0]    rem_a [NI];
  logic [7:0]    rrem_a[NI];
  logic [15:0]   cnt_a [NI];
  logic [NI-1:0] busy_v, done_v, div_v, abort_v, err_v;

  int errors = 0;
  int checks = 0;

  for (genvar gi = 0; gi < NI; gi++) begin : g_dut
    localparam int D  = DIVS[gi];
    localparam int CW = CWS[gi];
    localparam int R  = $clog2(D);
    logic [R-1:0]  rem, rrem;
    logic [CW-1:0] cnt;
    logic          busy, done, div, abort, err;
    mod_n_serial_checker #(.DIVISOR(D), .CNT_W(CW)) dut (
      .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .i_bit(i_bit), .i_sop(i_sop),
      .i_eop(i_eop), .i_lsb_first(i_lsb_first), .o_rem(rem), .o_busy(busy), .o_done(done),
      .o_result_rem(rrem), .o_result_div(div), .o_bit_count(cnt), .o_abort(abort), .o_err(err));
    assign rem_a[gi]   = 8'(rem);
    assign rrem_a[gi]  = 8'(rrem);
    assign cnt_a[gi]   = 16'(cnt);
    assign busy_v[gi]  = busy;
    assign done_v[gi]  = done;
    assign div_v[gi]   = div;
    assign abort_v[gi] = abort;
    assign err_v[gi]   = err;
  end

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic beat(input logic b, input logic sop, input logic eop, input logic lsb);
    i_valid = 1'b1; i_bit = b; i_sop = sop; i_eop = eop; i_lsb_first = lsb;
    @(posedge i_clk); #1;
    i_valid = 1'b0; i_sop = 1'b0; i_eop = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge i_clk); #1; end
  endtask

  task automatic test_reset();
    i_rst = 1'b1; idle(2); i_rst = 1'b0;
    checks++; if ({busy_v, done_v, div_v, abort_v, err_v} !== '0) begin errors++; $display("FAIL reset_flags got %h want 0", {busy_v, done_v, div_v, abort_v, err_v}); end
    for (int k = 0; k < NI; k++) begin
      checks++; if ({rem_a[k], rrem_a[k], cnt_a[k]} !== 32'd0) begin errors++; $display("FAIL reset_regs[%0d] got %h want 0", k, {rem_a[k], rrem_a[k], cnt_a[k]}); end
    end
  endtask

  // 110b = 6, MSB first
  task automatic test_msb6();
    beat(1, 1, 0, 0);
    checks++; if (rem_a[I3] !== 8'd1) begin errors++; $display("FAIL msb6_rem1 got %0d want 1", rem_a[I3]); end
    checks++; if (busy_v[I3] !== 1'b1) begin errors++; $display("FAIL msb6_busy got %b want 1", busy_v[I3]); end
    beat(1, 0, 0, 0);
    checks++; if (rem_a[I3] !== 8'd0) begin errors++; $display("FAIL msb6_rem2 got %0d want 0", rem_a[I3]); end
    checks++; if (done_v[I3] !== 1'b0) begin errors++; $display("FAIL msb6_early_done got %b want 0", done_v[I3]); end
    beat(0, 0, 1, 0);
    checks++; if (done_v[I3] !== 1'b1) begin errors++; $display("FAIL msb6_done got %b want 1", done_v[I3]); end
    checks++; if (rrem_a[I3] !== 8'd0 || div_v[I3] !== 1'b1) begin errors++; $display("FAIL msb6_result got %0d/%b want 0/1", rrem_a[I3], div_v[I3]); end
    checks++; if (cnt_a[I3] !== 16'd3) begin errors++; $display("FAIL msb6_count got %0d want 3", cnt_a[I3]); end
    checks++; if (busy_v[I3] !== 1'b0) begin errors++; $display("FAIL msb6_busy_end got %b want 0", busy_v[I3]); end
    checks++; if (rrem_a[I7] !== 8'd6) begin errors++; $display("FAIL msb6_mod7 got %0d want 6", rrem_a[I7]); end
    idle(1);
    checks++; if (done_v !== '0) begin errors++; $display("FAIL msb6_done_pulse got %b want 0", done_v); end
  endtask

  // bits 1,1,0 LSB first = 3; order latched on sop, ignored afterwards
  task automatic test_lsb3();
    beat(1, 1, 0, 1); beat(1, 0, 0, 0); beat(0, 0, 1, 0);
    checks++; if (rrem_a[I3] !== 8'd0 || div_v[I3] !== 1'b1) begin errors++; $display("FAIL lsb3_mod3 got %0d/%b want 0/1", rrem_a[I3], div_v[I3]); end
    checks++; if (rrem_a[I7] !== 8'd3 || div_v[I7] !== 1'b0) begin errors++; $display("FAIL lsb3_mod7 got %0d/%b want 3/0", rrem_a[I7], div_v[I7]); end
    checks++; if (rrem_a[I2] !== 8'd1) begin errors++; $display("FAIL lsb3_mod2 got %0d want 1", rrem_a[I2]); end
  endtask

  // 1010b = 10 mod 7, with gaps; non-valid cycles carry junk flags
  task automatic test_gaps();
    beat(1, 1, 0, 0);
    checks++; if (rem_a[I7] !== 8'd1) begin errors++; $display("FAIL gaps_rem1 got %0d want 1", rem_a[I7]); end
    beat(0, 0, 0, 0);
    checks++; if (rem_a[I7] !== 8'd2) begin errors++; $display("FAIL gaps_rem2 got %0d want 2", rem_a[I7]); end
    i_sop = 1'b1; i_eop = 1'b1; i_bit = 1'b1; idle(2); i_sop = 1'b0; i_eop = 1'b0;
    checks++; if (rem_a[I7] !== 8'd2 || busy_v[I7] !== 1'b1 || done_v[I7] !== 1'b0) begin errors++; $display("FAIL gaps_hold got %0d/%b/%b want 2/1/0", rem_a[I7], busy_v[I7], done_v[I7]); end
    beat(1, 0, 0, 0);
    checks++; if (rem_a[I7] !== 8'd5) begin errors++; $display("FAIL gaps_rem3 got %0d want 5", rem_a[I7]); end
    idle(3);
    beat(0, 0, 1, 0);
    checks++; if (rem_a[I7] !== 8'd3) begin errors++; $display("FAIL gaps_rem4 got %0d want 3", rem_a[I7]); end
    checks++; if (done_v[I7] !== 1'b1 || rrem_a[I7] !== 8'd3 || div_v[I7] !== 1'b0) begin errors++; $display("FAIL gaps_result got %b/%0d/%b want 1/3/0", done_v[I7], rrem_a[I7], div_v[I7]); end
    checks++; if (cnt_a[I7] !== 16'd4) begin errors++; $display("FAIL gaps_count got %0d want 4", cnt_a[I7]); end
  endtask

  task automatic test_single_and_stray();
    beat(0, 1, 1, 0);
    checks++; if (done_v[I3] !== 1'b1 || div_v[I3] !== 1'b1 || rrem_a[I3] !== 8'd0) begin errors++; $display("FAIL single_result got %b/%b/%0d want 1/1/0", done_v[I3], div_v[I3], rrem_a[I3]); end
    checks++; if (cnt_a[I3] !== 16'd1 || busy_v[I3] !== 1'b0) begin errors++; $display("FAIL single_cnt_busy got %0d/%b want 1/0", cnt_a[I3], busy_v[I3]); end
    beat(1, 0, 1, 0);
    checks++; if (err_v !== '1) begin errors++; $display("FAIL stray_err got %b want 11111", err_v); end
    checks++; if (done_v[I3] !== 1'b0 || div_v[I3] !== 1'b1 || cnt_a[I3] !== 16'd1) begin errors++; $display("FAIL stray_hold got %b/%b/%0d want 0/1/1", done_v[I3], div_v[I3], cnt_a[I3]); end
    idle(1);
    checks++; if (err_v !== '0) begin errors++; $display("FAIL stray_err_pulse got %b want 0", err_v); end
  endtask

  task automatic test_restart();
    logic [4:0] first = 5'b11101;
    int dones = 0;
    for (int i = 0; i < 5; i++) begin
      beat(first[i], i == 0, 1'b0, 1'b0);
      if (done_v[I3]) dones++;
    end
    beat(1, 1, 0, 0);
    if (done_v[I3]) dones++;
    checks++; if (abort_v[I3] !== 1'b1) begin errors++; $display("FAIL restart_abort got %b want 1", abort_v[I3]); end
    checks++; if (rem_a[I3] !== 8'd1 || busy_v[I3] !== 1'b1) begin errors++; $display("FAIL restart_rem got %0d/%b want 1/1", rem_a[I3], busy_v[I3]); end
    beat(0, 0, 0, 0);
    checks++; if (abort_v[I3] !== 1'b0 || rem_a[I3] !== 8'd2) begin errors++; $display("FAIL restart_next got %b/%0d want 0/2", abort_v[I3], rem_a[I3]); end
    beat(0, 0, 1, 0);
    checks++; if (dones !== 0) begin errors++; $display("FAIL restart_no_done got %0d want 0", dones); end
    checks++; if (done_v[I3] !== 1'b1 || rrem_a[I3] !== 8'd1 || cnt_a[I3] !== 16'd3) begin errors++; $display("FAIL restart_result got %b/%0d/%0d want 1/1/3", done_v[I3], rrem_a[I3], cnt_a[I3]); end
  endtask

  task automatic test_back_to_back();
    beat(1, 1, 0, 0); beat(1, 0, 0, 0); beat(1, 0, 1, 0);
    checks++; if (done_v[I7] !== 1'b1 || rrem_a[I7] !== 8'd0 || div_v[I7] !== 1'b1) begin errors++; $display("FAIL b2b_a got %b/%0d/%b want 1/0/1", done_v[I7], rrem_a[I7], div_v[I7]); end
    beat(1, 1, 0, 1);
    checks++; if (done_v[I7] !== 1'b0 || abort_v[I7] !== 1'b0 || rem_a[I7] !== 8'd1) begin errors++; $display("FAIL b2b_sop got %b/%b/%0d want 0/0/1", done_v[I7], abort_v[I7], rem_a[I7]); end
    beat(0, 0, 0, 0); beat(1, 0, 1, 0);
    checks++; if (done_v[I7] !== 1'b1 || rrem_a[I7] !== 8'd5 || cnt_a[I7] !== 16'd3) begin errors++; $display("FAIL b2b_b got %b/%0d/%0d want 1/5/3", done_v[I7], rrem_a[I7], cnt_a[I7]); end
    beat(1, 1, 1, 0);
    checks++; if (done_v[I7] !== 1'b1 || rrem_a[I7] !== 8'd1 || cnt_a[I7] !== 16'd1 || busy_v[I7] !== 1'b0) begin errors++; $display("FAIL b2b_c got %b/%0d/%0d/%b want 1/1/1/0", done_v[I7], rrem_a[I7], cnt_a[I7], busy_v[I7]); end
  endtask

  task automatic test_reset_mid();
    beat(1, 1, 0, 0); beat(1, 0, 0, 0);
    i_rst = 1'b1; idle(1); i_rst = 1'b0;
    checks++; if ({busy_v, done_v, abort_v} !== '0) begin errors++; $display("FAIL rstmid_flags got %h want 0", {busy_v, done_v, abort_v}); end
    checks++; if (rem_a[I3] !== 8'd0 || rrem_a[I7] !== 8'd0 || cnt_a[I7] !== 16'd0) begin errors++; $display("FAIL rstmid_regs got %0d/%0d/%0d want 0/0/0", rem_a[I3], rrem_a[I7], cnt_a[I7]); end
    beat(1, 0, 0, 0);
    checks++; if (err_v !== '1 || busy_v !== '0) begin errors++; $display("FAIL rstmid_idle got %b/%b want 11111/00000", err_v, busy_v); end
  endtask

  // Reference: build the frame's integer value directly and take % of it.
  task automatic test_random();
    for (int f = 0; f < 2000; f++) begin
      int n = $urandom_range(1, 40);
      logic lsb = 1'($urandom_range(0, 1));
      longint unsigned val = 0;
      for (int i = 0; i < n; i++) begin
        logic b = 1'($urandom_range(0, 1));
        if (lsb) val = val | (longint'(b) << i);
        else     val = (val << 1) | longint'(b);
        if ($urandom_range(0, 7) == 0) idle(1);
        beat(b, i == 0, i == n - 1, lsb);
      end
      for (int k = 0; k < NI; k++) begin
        int er = int'(val % longint'(DIVS[k]));
        int ec = (n > CMAX[k]) ? CMAX[k] : n;
        checks++; if (done_v[k] !== 1'b1) begin errors++; $display("FAIL rand%0d_done[%0d] got %b want 1", f, k, done_v[k]); end
        checks++; if (rrem_a[k] !== 8'(er)) begin errors++; $display("FAIL rand%0d_rem[%0d] got %0d want %0d", f, k, rrem_a[k], er); end
        checks++; if (div_v[k] !== (er == 0)) begin errors++; $display("FAIL rand%0d_div[%0d] got %b want %b", f, k, div_v[k], er == 0); end
        checks++; if (cnt_a[k] !== 16'(ec)) begin errors++; $display("FAIL rand%0d_cnt[%0d] got %0d want %0d", f, k, cnt_a[k], ec); end
      end
    end
  endtask

  initial begin
    i_rst = 1'b1; i_valid = 1'b0; i_bit = 1'b0; i_sop = 1'b0; i_eop = 1'b0; i_lsb_first = 1'b0;
    test_reset();
    test_msb6();
    test_lsb3();
    test_gaps();
    test_single_and_stray();
    test_restart();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
